// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

   // funct3 width/sign codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // byte enables
   localparam logic [3:0] BE_B0   = 4'b0001;
   localparam logic [3:0] BE_LO_H = 4'b0011;
   localparam logic [3:0] BE_HI_H = 4'b1100;
   localparam logic [3:0] BE_W    = 4'b1111;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} lsu_state_e;

   // access fields latched in IDLE and held for the whole transaction
   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  funct3;
      logic [1:0]  off;
   } lsu_req_t;

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select plus sign/zero extension (purely combinational).
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // pick the addressed byte/halfword, then extend by funct3
   always_comb begin
      lane_b = word[{off, 3'b000} +: 8];
      lane_h = off[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_B:    result = {{24{lane_b[7]}}, lane_b};
         F3_H:    result = {{16{lane_h[15]}}, lane_h};
         F3_BU:   result = {24'b0, lane_b};
         F3_HU:   result = {16'b0, lane_h};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Core-side data-memory access unit: lane steering, req/gnt/rvalid handshake,
// core stall and fault reporting (illegal/misaligned access, timeout).
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        stall_o,
   output logic        fault_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i
);

   localparam int CW = 16;

   lsu_state_e    state, state_nxt;
   lsu_req_t      req_q, req_d;
   logic [CW-1:0] cnt;
   logic          to_q;        // current access ended by timeout
   logic          access, f3_ok, aligned, legal, illegal, timeout_hit;
   logic [31:0]   ld_result;

   lsu_load_align u_align (
      .word   (dmem_rdata_i),
      .off    (req_q.off),
      .funct3 (req_q.funct3),
      .result (ld_result)
   );

   // decode the incoming access: legality and store lane steering
   always_comb begin
      access = mem_read_i | mem_write_i;
      if (mem_write_i) f3_ok = funct3_i inside {F3_B, F3_H, F3_W};
      else             f3_ok = funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
      case (funct3_i[1:0])
         2'b01:   aligned = ~addr_i[0];
         2'b10:   aligned = (addr_i[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
      legal   = access & f3_ok & aligned;
      illegal = access & ~(f3_ok & aligned);

      req_d.we     = mem_write_i;   // read+write together is a store
      req_d.addr   = {addr_i[31:2], 2'b00};
      req_d.funct3 = funct3_i;
      req_d.off    = addr_i[1:0];
      req_d.be     = BE_W;
      req_d.wdata  = '0;
      if (mem_write_i) begin
         case (funct3_i[1:0])
            2'b00: begin
               req_d.be    = BE_B0 << addr_i[1:0];
               req_d.wdata = {4{wdata_i[7:0]}};
            end
            2'b01: begin
               req_d.be    = addr_i[1] ? BE_HI_H : BE_LO_H;
               req_d.wdata = {2{wdata_i[15:0]}};
            end
            default: req_d.wdata = wdata_i;
         endcase
      end
   end

   assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next state; DONE never looks at the inputs so the retiring
   // instruction cannot start a second access
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (legal) state_nxt = REQ;
         REQ:     if (dmem_gnt_i) state_nxt = req_q.we ? DONE : WAIT_R;
                  else if (timeout_hit) state_nxt = DONE;
         WAIT_R:  if (dmem_rvalid_i || timeout_hit) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // latched request, timeout counter and load result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q   <= '0;
         cnt     <= '0;
         to_q    <= 1'b0;
         rdata_o <= '0;
      end else begin
         case (state)
            IDLE: if (legal) begin
               req_q <= req_d;
               cnt   <= '0;
               to_q  <= 1'b0;
            end
            REQ: begin
               if (dmem_gnt_i) cnt <= '0;
               else if (timeout_hit) begin
                  to_q    <= 1'b1;
                  rdata_o <= '0;
               end else cnt <= cnt + 1'b1;
            end
            WAIT_R: begin
               if (dmem_rvalid_i) rdata_o <= ld_result;
               else if (timeout_hit) begin
                  to_q    <= 1'b1;
                  rdata_o <= '0;
               end else cnt <= cnt + 1'b1;
            end
            default: begin
               to_q <= 1'b0;
               cnt  <= '0;
            end
         endcase
      end
   end

   // stall/fault depend on live inputs in IDLE, so gate them with reset
   // to keep them low while the unit is held in reset
   assign stall_o = rst_n & ((state == IDLE && legal) || state == REQ || state == WAIT_R);
   assign fault_o = rst_n & ((state == IDLE && illegal) || (state == DONE && to_q));

   assign dmem_req_o   = (state == REQ);
   assign dmem_we_o    = req_q.we;
   assign dmem_addr_o  = req_q.addr;
   assign dmem_be_o    = req_q.be;
   assign dmem_wdata_o = req_q.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a transaction-level reference model.
module tb_load_store_unit;
   import lsu_pkg::*;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_read = 1'b0, mem_write = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] addr = '0, wdata = '0;
   logic [31:0] rdata;
   logic        stall, fault, req, we;
   logic [31:0] maddr, mwdata;
   logic [3:0]  be;
   logic        gnt = 1'b0, rvalid = 1'b0;
   logic [31:0] mrdata = '0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_read_i(mem_read), .mem_write_i(mem_write), .funct3_i(funct3),
      .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata),
      .stall_o(stall), .fault_o(fault),
      .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(maddr), .dmem_be_o(be),
      .dmem_wdata_o(mwdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
      .dmem_rdata_i(mrdata)
   );

   int total = 0, bad = 0;

   // expected outputs for the current cycle
   logic        chk_en = 1'b0;
   logic        e_stall = 1'b0, e_req = 1'b0, e_fault = 1'b0, e_we = 1'b0;
   logic [3:0]  e_be = '0;
   logic [31:0] e_addr = '0, e_wdata = '0, e_rdata = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // model: load extraction by shifting the word down to the addressed lane
   function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] a,
                                          input logic [2:0] f3);
      logic [31:0] s, hs;
      s  = w >> (8 * a);
      hs = w >> (16 * a[1]);
      case (f3)
         3'd0:    return 32'($signed(s[7:0]));
         3'd1:    return 32'($signed(hs[15:0]));
         3'd4:    return {24'b0, s[7:0]};
         3'd5:    return {16'b0, hs[15:0]};
         default: return w;
      endcase
   endfunction

   function automatic logic m_legal(input logic rd, input logic wr, input logic [2:0] f3,
                                    input logic [1:0] a);
      logic okf, al;
      okf = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      al  = (f3[1:0] == 2'd1) ? !a[0] : (f3[1:0] == 2'd2) ? (a == 2'd0) : 1'b1;
      return (rd || wr) && okf && al;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] a);
      if (f3[1:0] == 2'd0) return 4'(1 << a);
      if (f3[1:0] == 2'd1) return a[1] ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
      if (f3[1:0] == 2'd0) return {24'b0, d[7:0]} * 32'h01010101;
      if (f3[1:0] == 2'd1) return {16'b0, d[15:0]} * 32'h00010001;
      return d;
   endfunction

   // compare DUT against the model every cycle
   always @(negedge clk) begin
      if (chk_en) begin
         check("stall", {31'b0, stall}, {31'b0, e_stall});
         check("req", {31'b0, req}, {31'b0, e_req});
         check("fault", {31'b0, fault}, {31'b0, e_fault});
         check("rdata", rdata, e_rdata);
         if (e_req) begin
            check("we", {31'b0, we}, {31'b0, e_we});
            check("be", {28'b0, be}, {28'b0, e_be});
            check("addr", maddr, e_addr);
            if (e_we) check("wdata", mwdata, e_wdata);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // one instruction: gw = wait cycles before gnt (>= TO means never),
   // rw = wait cycles between gnt and rvalid
   task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] word, input int gw, input int rw);
      logic lg, st, tmo;
      int   n;
      lg  = m_legal(rd, wr, f3, a[1:0]);
      st  = wr;
      tmo = (gw >= TO);
      cyc();
      mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = d;
      gnt = 0; rvalid = 0;
      e_stall = lg; e_fault = !lg; e_req = 0;
      if (!lg) begin
         cyc();
         mem_read = 0; mem_write = 0;
         e_fault = 0; e_stall = 0;
         return;
      end
      e_we    = st;
      e_be    = st ? m_be(f3, a[1:0]) : 4'hF;
      e_addr  = {a[31:2], 2'b00};
      e_wdata = m_wdata(f3, d);
      n = tmo ? TO : gw + 1;
      for (int i = 0; i < n; i++) begin
         cyc();
         gnt = !tmo && (i == n - 1);
         e_req = 1; e_stall = 1;
      end
      if (!tmo && !st) begin
         for (int i = 0; i <= rw; i++) begin
            cyc();
            gnt = 0;
            rvalid = (i == rw);
            mrdata = rvalid ? word : 32'hDEADBEEF;
            e_req = 0; e_stall = 1;
         end
      end
      cyc();
      gnt = 0; rvalid = 0; mrdata = 32'h0BAD0BAD;
      e_req = 0; e_stall = 0; e_fault = tmo;
      if (tmo) e_rdata = 32'h0;
      else if (!st) e_rdata = m_load(word, a[1:0], f3);
      cyc();
      mem_read = 0; mem_write = 0;
      e_fault = 0;
   endtask

   initial begin
      // reset state
      #12;
      check("rst stall", {31'b0, stall}, 32'h0);
      check("rst req", {31'b0, req}, 32'h0);
      check("rst fault", {31'b0, fault}, 32'h0);
      check("rst rdata", rdata, 32'h0);
      check("rst be", {28'b0, be}, 32'h0);
      check("rst wdata", mwdata, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      chk_en = 1;

      // hand-computed pins on the model itself
      check("model LB", m_load(32'h80FF7F01, 2'd2, F3_B), 32'hFFFFFFFF);
      check("model LBU", m_load(32'h80FF7F01, 2'd2, F3_BU), 32'h000000FF);
      check("model LH", m_load(32'h80FF7F01, 2'd2, F3_H), 32'hFFFF80FF);
      check("model LHU", m_load(32'h80FF7F01, 2'd2, F3_HU), 32'h000080FF);
      check("model SB be", {28'b0, m_be(F3_B, 2'd3)}, 32'h8);
      check("model SB wdata", m_wdata(F3_B, 32'hAB), 32'hABABABAB);

      // stores
      access(0, 1, F3_B, 32'h1003, 32'hAB, 0, 2, 0);
      access(0, 1, F3_H, 32'h1002, 32'h1234ABCD, 0, 1, 0);
      access(0, 1, F3_H, 32'h1000, 32'h1234ABCD, 0, 0, 0);
      access(0, 1, F3_W, 32'h1004, 32'hCAFEBABE, 0, 0, 0);
      access(1, 1, F3_B, 32'h1001, 32'h5A, 0, 0, 0);      // read+write -> store

      // loads
      access(1, 0, F3_B, 32'h2002, 0, 32'h80FF7F01, 0, 0);
      check("LB literal", rdata, 32'hFFFFFFFF);
      access(1, 0, F3_BU, 32'h2002, 0, 32'h80FF7F01, 0, 0);
      check("LBU literal", rdata, 32'h000000FF);
      access(1, 0, F3_H, 32'h2002, 0, 32'h80FF7F01, 0, 0);
      check("LH literal", rdata, 32'hFFFF80FF);
      access(1, 0, F3_HU, 32'h2002, 0, 32'h80FF7F01, 0, 0);
      check("LHU literal", rdata, 32'h000080FF);
      access(1, 0, F3_B, 32'h2001, 0, 32'h80FF7F01, 0, 1);
      access(1, 0, F3_W, 32'h2000, 0, 32'h13579BDF, 3, 2);

      // faults: misaligned / illegal funct3
      access(1, 0, F3_W, 32'h3001, 0, 0, 0, 0);
      access(1, 0, 3'b011, 32'h3000, 0, 0, 0, 0);
      access(0, 1, F3_H, 32'h3003, 32'h1, 0, 0, 0);
      access(0, 1, F3_BU, 32'h3000, 32'h1, 0, 0, 0);
      check("rdata after faults", rdata, 32'h13579BDF);

      // timeout: gnt never comes
      access(1, 0, F3_W, 32'h4000, 0, 0, 100, 0);
      check("timeout rdata", rdata, 32'h0);

      // late rvalid in IDLE must be ignored
      cyc(); rvalid = 1; mrdata = 32'h55555555;
      cyc(); rvalid = 0;

      // reset while waiting for read data
      chk_en = 0;
      access(1, 0, F3_W, 32'h4004, 0, 32'h11223344, 0, 0);
      cyc(); mem_read = 1; funct3 = F3_W; addr = 32'h5000;
      cyc(); gnt = 1;
      cyc(); gnt = 0;
      check("pre-reset stall", {31'b0, stall}, 32'h1);
      rst_n = 0;
      #1;
      check("reset req", {31'b0, req}, 32'h0);
      check("reset stall", {31'b0, stall}, 32'h0);
      check("reset fault", {31'b0, fault}, 32'h0);
      cyc();
      mem_read = 0; rst_n = 1;
      e_rdata = 0; e_stall = 0; e_req = 0; e_fault = 0;
      chk_en = 1;
      access(1, 0, F3_W, 32'h5004, 0, 32'hCAFEF00D, 1, 1);
      check("post-reset LW", rdata, 32'hCAFEF00D);

      cyc(); cyc();
      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
